// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Front-end conditioning for the safe's push-buttons and switches. Each raw
// pad level is brought into the clock domain with a two-flop synchroniser,
// then debounced on a shared, prescaled sample strobe. A new level is only
// committed after STABLE consecutive samples that disagree with the current
// level; any agreeing sample throws the partial run away.
//
// Parameters
//   CH      number of channels (0=a, 1=b, 2=lock, 3=open, 4=doorCls)
//   div     clk cycles per sample tick (>= 1)
//   STABLE  consecutive differing samples needed to commit (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   raw          unsynchronised pad levels
//   level        debounced, registered level per channel
//   rise         one-clk pulse on a committed 0->1 change
//   fall         one-clk pulse on a committed 1->0 change
//   sample_tick  one-clk strobe marking each sample instant
//
// Handshake note: there is no valid/ready flow here. sample_tick, rise and
// fall are single-cycle strobes; level is a plain registered level. All
// outputs come from flops, so nothing combinational reaches an output from
// raw.
// ---------------------------------------------------------------------------
module input_conditioner #(
    parameter int CH     = 5,
    parameter int div    = 25000,
    parameter int STABLE = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] raw,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          sample_tick
);

    // Counter widths; both are at least one bit so div=1 / STABLE=1 still
    // elaborate to legal vectors.
    localparam int PW = (div    > 1) ? $clog2(div)    : 1;
    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(div - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    // -----------------------------------------------------------------------
    // Two-flop synchroniser
    // -----------------------------------------------------------------------
    logic [CH-1:0] sync1_q;
    logic [CH-1:0] sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Prescaler
    //
    // The strobe is registered so that it is 0 during reset even for div=1.
    // pre_q counts edges since release modulo div; the strobe is loaded when
    // the count is about to wrap, which makes the first tick visible exactly
    // div clocks after reset release and then every div clocks.
    // -----------------------------------------------------------------------
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick_q;
    logic          tick_d;

    always_comb begin
        pre_d  = pre_q;
        tick_d = 1'b0;
        if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end else begin
            pre_d  = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel debounce
    //
    // Only cycles carrying the strobe do anything. A sample equal to the
    // current level restarts the run; a differing sample either extends the
    // run or, if it is the STABLE-th in a row, commits the new level. The
    // counter therefore never exceeds STABLE-1.
    //
    // rise/fall default to 0 every cycle, so they are one clk wide and line up
    // with the first cycle of the new level.
    // -----------------------------------------------------------------------
    logic [CH-1:0][CW-1:0] cnt_q;
    logic [CH-1:0][CW-1:0] cnt_d;
    logic [CH-1:0]         level_q;
    logic [CH-1:0]         level_d;
    logic [CH-1:0]         rise_q;
    logic [CH-1:0]         rise_d;
    logic [CH-1:0]         fall_q;
    logic [CH-1:0]         fall_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        if (tick_q) begin
            for (int i = 0; i < CH; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                    // level differs from sync here, so exactly one of these
                    // is set: rise when moving to 1, fall when moving to 0.
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level       = level_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//
// Two instances: dut_a (div=4, STABLE=3) and dut_b (div=1, STABLE=1), sharing
// clock and reset. A reference model predicts every output of both every
// cycle: the synchroniser is a raw-value history, the sample strobe is the
// edge count since release modulo div, and a commit happens when the last
// STABLE samples taken all disagree with the current level.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int CH = 5;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [CH-1:0] raw_a = '0;
    logic [CH-1:0] raw_b = '0;
    logic [CH-1:0] level_a, rise_a, fall_a;
    logic [CH-1:0] level_b, rise_b, fall_b;
    logic          tick_a, tick_b;

    input_conditioner #(.CH(CH), .div(4), .STABLE(3)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .raw         (raw_a),
        .level       (level_a),
        .rise        (rise_a),
        .fall        (fall_a),
        .sample_tick (tick_a)
    );

    input_conditioner #(.CH(CH), .div(1), .STABLE(1)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .raw         (raw_b),
        .level       (level_b),
        .rise        (rise_b),
        .fall        (fall_b),
        .sample_tick (tick_b)
    );

    // -----------------------------------------------------------------------
    // Scoreboard counters and checking task
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model (index 0 = dut_a, 1 = dut_b)
    // -----------------------------------------------------------------------
    int            div_m [2] = '{4, 1};
    int            stb_m [2] = '{3, 1};
    int            k_m   [2];          // edges since reset release
    logic [CH-1:0] rawh  [2][2];       // [0] newest raw seen at an edge
    int            nraw  [2];
    logic [CH-1:0] samp  [2][8];       // [0] newest sampled sync value
    int            nsamp [2];
    logic [CH-1:0] lvl_m [2];
    logic [CH-1:0] rise_m[2];
    logic [CH-1:0] fall_m[2];
    logic          tick_m[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            k_m[d]    = 0;
            nraw[d]   = 0;
            nsamp[d]  = 0;
            lvl_m[d]  = '0;
            rise_m[d] = '0;
            fall_m[d] = '0;
            tick_m[d] = 1'b0;
            rawh[d][0] = '0;
            rawh[d][1] = '0;
            for (int j = 0; j < 8; j++) samp[d][j] = '0;
        end
    endtask

    // Advance one dut's model across one rising edge; raw_now is the raw
    // value present at that edge.
    task automatic model_step(input int d, input logic [CH-1:0] raw_now);
        int            prev;
        logic [CH-1:0] sync_prev;
        logic          all_diff;
        prev      = k_m[d];
        k_m[d]    = k_m[d] + 1;
        // sync seen just before this edge is raw from two edges back
        sync_prev = (nraw[d] >= 2) ? rawh[d][1] : '0;
        rise_m[d] = '0;
        fall_m[d] = '0;
        if (prev > 0 && (prev % div_m[d]) == 0) begin
            for (int j = 7; j > 0; j--) samp[d][j] = samp[d][j-1];
            samp[d][0] = sync_prev;
            if (nsamp[d] < 8) nsamp[d]++;
            for (int c = 0; c < CH; c++) begin
                if (nsamp[d] >= stb_m[d]) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < stb_m[d]; j++)
                        if (samp[d][j][c] == lvl_m[d][c]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (lvl_m[d][c]) fall_m[d][c] = 1'b1;
                        else             rise_m[d][c] = 1'b1;
                        lvl_m[d][c] = ~lvl_m[d][c];
                    end
                end
            end
        end
        rawh[d][1] = rawh[d][0];
        rawh[d][0] = raw_now;
        if (nraw[d] < 2) nraw[d]++;
        tick_m[d] = ((k_m[d] % div_m[d]) == 0);
    endtask

    logic running = 1'b0;

    // Model update and compare, 1 time unit after each rising edge. raw only
    // changes on falling edges, so it still holds the value the edge saw.
    always @(posedge clk) begin
        logic [CH-1:0] ra, rb;
        ra = raw_a;
        rb = raw_b;
        #1;
        if (running) begin
            if (!reset) begin
                model_reset();
            end else begin
                model_step(0, ra);
                model_step(1, rb);
            end
            check("a_level", 32'(level_a), 32'(lvl_m[0]));
            check("a_rise",  32'(rise_a),  32'(rise_m[0]));
            check("a_fall",  32'(fall_a),  32'(fall_m[0]));
            check("a_tick",  32'(tick_a),  32'(tick_m[0]));
            check("b_level", 32'(level_b), 32'(lvl_m[1]));
            check("b_rise",  32'(rise_b),  32'(rise_m[1]));
            check("b_fall",  32'(fall_b),  32'(fall_m[1]));
            check("b_tick",  32'(tick_b),  32'(tick_m[1]));
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    // Wait n falling edges; dut_b's raw is toggled randomly along the way so
    // the div=1/STABLE=1 instance sees both isolated toggles and bursts.
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) raw_b = CH'($urandom);
        end
    endtask

    task automatic set_a_bit(input int c, input logic v);
        raw_a[c] = v;
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        model_reset();
        raw_a = '1;
        raw_b = '1;
        running = 1'b1;

        // Reset held with all raws high: everything stays 0.
        wait_cyc(5);
        reset = 1'b1;
        // level_a reaches 5'b11111 at the third tick (edge 13 after release).
        wait_cyc(20);

        // Clean release then press on ch0.
        set_a_bit(0, 1'b0);
        wait_cyc(20);
        set_a_bit(0, 1'b1);
        wait_cyc(20);

        // Bounce on ch1: get it to 0, then high 2 ticks, low 1 tick, high.
        set_a_bit(1, 1'b0);
        wait_cyc(20);
        set_a_bit(1, 1'b1);
        wait_cyc(8);
        set_a_bit(1, 1'b0);
        wait_cyc(4);
        set_a_bit(1, 1'b1);
        wait_cyc(24);

        // Simultaneous: ch2 at 1, ch3 at 0, then flip both in one clk.
        set_a_bit(3, 1'b0);
        wait_cyc(20);
        raw_a[2] = 1'b0;
        raw_a[3] = 1'b1;
        wait_cyc(20);

        // Reset mid-count on ch4.
        set_a_bit(4, 1'b0);
        wait_cyc(10);
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        wait_cyc(24);

        // Randomised run: random hold lengths include sub-tick glitches,
        // runs just short of STABLE ticks, and long stable stretches.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 1) == 0)
                raw_a = CH'($urandom);
            else
                raw_a[$urandom_range(0, CH-1)] = ~raw_a[$urandom_range(0, CH-1)];
            wait_cyc($urandom_range(1, 16));
            if ($urandom_range(0, 60) == 0) begin
                reset = 1'b0;
                wait_cyc($urandom_range(1, 3));
                reset = 1'b1;
            end
        end

        wait_cyc(20);
        running = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
